// File: rtl/ex_stage_pkg.sv
// Shared CPU definitions for the execute stage: opcodes, forwarding selects,
// flag bit positions and the opcode-to-flag-write classification.
package ex_stage_pkg;

  localparam int DATA_W = 16;
  localparam int FLAG_W = 3;

  // Bit positions inside the {Z,V,N} flag vector
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_WB      = 2'b01,
    FWD_MEM     = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    FL_NONE,
    FL_Z,
    FL_ZVN
  } flag_class_e;

  function automatic flag_class_e flag_class(input opcode_e op);
    case (op)
      OP_ADD, OP_SUB:                 return FL_ZVN;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: return FL_Z;
      default:                        return FL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX-to-EX bundle: operands, controls, forwarding and the stage results.
interface ex_stage_if;

  logic        stall;
  logic [15:0] EX_instr;
  logic [15:0] EX_pc;
  logic [15:0] EX_ReadData1;
  logic [15:0] EX_ReadData2;
  logic [15:0] EX_Imm;
  logic        EX_ALUSrc;
  logic        EX_FLAG_Enable;
  logic        EX_LoadUpper;
  logic        EX_PCSave;
  logic [1:0]  fwdA;
  logic [1:0]  fwdB;
  logic [15:0] MEM_ALUResult;
  logic [15:0] WB_WriteData;
  logic [15:0] EX_ALUResult;
  logic [15:0] EX_StoreData;
  logic [2:0]  FLAGS;

  modport master (
    output stall, EX_instr, EX_pc, EX_ReadData1, EX_ReadData2, EX_Imm,
           EX_ALUSrc, EX_FLAG_Enable, EX_LoadUpper, EX_PCSave,
           fwdA, fwdB, MEM_ALUResult, WB_WriteData,
    input  EX_ALUResult, EX_StoreData, FLAGS
  );

  modport slave (
    input  stall, EX_instr, EX_pc, EX_ReadData1, EX_ReadData2, EX_Imm,
           EX_ALUSrc, EX_FLAG_Enable, EX_LoadUpper, EX_PCSave,
           fwdA, fwdB, MEM_ALUResult, WB_WriteData,
    output EX_ALUResult, EX_StoreData, FLAGS
  );

endinterface

// File: rtl/ex_stage_alu16.sv
// Combinational 16-bit ALU: saturating add/sub, bitwise/shift ops, RED,
// PADDSB, address and load-byte forms, with PC-save override.
module alu16
  import ex_stage_pkg::*;
(
  input  opcode_e                  op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] imm,
  input  logic        [DATA_W-1:0] pc,
  input  logic                     pc_save,
  input  logic                     load_upper,
  output logic signed [DATA_W-1:0] result,
  output logic                     sat
);

  function automatic logic sat_ovf17(input logic signed [16:0] x);
    return x[16] ^ x[15];
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
    if (sat_ovf17(x)) return x[16] ? 16'sh8000 : 16'sh7FFF;
    return x[15:0];
  endfunction

  function automatic logic signed [3:0] sat4(input logic signed [4:0] x);
    if (x[4] ^ x[3]) return x[4] ? 4'sh8 : 4'sh7;
    return x[3:0];
  endfunction

  logic signed [16:0] add_w, sub_w;
  logic signed [9:0]  red_w;
  logic        [15:0] paddsb_w;
  logic        [31:0] ror_w;
  logic        [3:0]  shamt;

  assign shamt = b[3:0];
  assign add_w = {a[15], a} + {b[15], b};
  assign sub_w = {a[15], a} - {b[15], b};
  assign red_w = ({{2{a[15]}}, a[15:8]} + {{2{b[15]}}, b[15:8]})
               + ({{2{a[7]}},  a[7:0]}  + {{2{b[7]}},  b[7:0]});
  // Rotating the doubled word leaves the rotated value in the low half
  assign ror_w = {a, a} >> shamt;

  always_comb begin
    paddsb_w = '0;
    for (int i = 0; i < 4; i++) begin
      paddsb_w[4*i +: 4] = sat4({a[4*i+3], a[4*i +: 4]} + {b[4*i+3], b[4*i +: 4]});
    end
  end

  always_comb begin
    result = '0;
    sat    = 1'b0;
    if (pc_save) begin
      result = pc;
    end else begin
      case (op)
        OP_ADD: begin
          result = sat16(add_w);
          sat    = sat_ovf17(add_w);
        end
        OP_SUB: begin
          result = sat16(sub_w);
          sat    = sat_ovf17(sub_w);
        end
        OP_XOR:         result = a ^ b;
        OP_SLL:         result = a << shamt;
        OP_SRA:         result = a >>> shamt;
        OP_ROR:         result = ror_w[15:0];
        OP_RED:         result = {{6{red_w[9]}}, red_w};
        OP_PADDSB:      result = paddsb_w;
        OP_LW, OP_SW:   result = {a[15:1], 1'b0} + imm;
        OP_LLB, OP_LHB: result = load_upper ? {imm[7:0], a[7:0]} : {a[15:8], imm[7:0]};
        default:        result = '0;
      endcase
    end
  end

endmodule

// File: rtl/pldff.sv
// Loadable D flip-flop bank with asynchronous active-high clear.
module pldff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (wen) q <= d;
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding/ALUSrc operand muxes, alu16 datapath and the
// {Z,V,N} flag register consumed by branch resolution.
module ex_stage
  import ex_stage_pkg::*;
(
  input logic         clk,
  input logic         rst,
  ex_stage_if.slave   ex
);

  function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
                                                input logic [DATA_W-1:0] reg_val,
                                                input logic [DATA_W-1:0] wb_val,
                                                input logic [DATA_W-1:0] mem_val);
    case (fwd_sel_e'(sel))
      FWD_WB:  return wb_val;
      FWD_MEM: return mem_val;
      default: return reg_val;
    endcase
  endfunction

  logic signed [DATA_W-1:0] op_a, op_bf, op_b, result;
  logic                     sat;
  opcode_e                  opcode;
  flag_class_e              cls;
  logic        [FLAG_W-1:0] flags_p0, flags_p1;
  logic                     flags_wen;
  logic                     unused_instr;

  assign opcode       = opcode_e'(ex.EX_instr[15:12]);
  assign unused_instr = ^ex.EX_instr[11:0];

  assign op_a  = fwd_mux(ex.fwdA, ex.EX_ReadData1, ex.WB_WriteData, ex.MEM_ALUResult);
  assign op_bf = fwd_mux(ex.fwdB, ex.EX_ReadData2, ex.WB_WriteData, ex.MEM_ALUResult);
  assign op_b  = ex.EX_ALUSrc ? ex.EX_Imm : op_bf;

  alu16 u_alu (
    .op         (opcode),
    .a          (op_a),
    .b          (op_b),
    .imm        (ex.EX_Imm),
    .pc         (ex.EX_pc),
    .pc_save    (ex.EX_PCSave),
    .load_upper (ex.EX_LoadUpper),
    .result     (result),
    .sat        (sat)
  );

  assign ex.EX_ALUResult = result;
  assign ex.EX_StoreData = op_bf;

  // Flags not owned by the current opcode class are rewritten with their held value
  always_comb begin
    cls              = flag_class(opcode);
    flags_p0         = flags_p1;
    flags_p0[FLAG_Z] = (result == '0);
    if (cls == FL_ZVN) begin
      flags_p0[FLAG_V] = sat;
      flags_p0[FLAG_N] = result[DATA_W-1];
    end
    flags_wen = ex.EX_FLAG_Enable & ~ex.stall & (cls != FL_NONE);
  end

  // EX -> flag register boundary
  pldff #(.WIDTH(FLAG_W)) u_flags (
    .clk (clk),
    .rst (rst),
    .wen (flags_wen),
    .d   (flags_p0),
    .q   (flags_p1)
  );

  assign ex.FLAGS = flags_p1;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected results queued at drive time and
// compared against the combinational outputs and the registered flags.
module tb_ex_stage;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] exp_res_q[$];
  logic [15:0] exp_sd_q[$];
  logic [2:0]  flags_exp;

  ex_stage_if bus ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] clamp16(input int v);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic [15:0] model(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [15:0] imm,
                                        input logic [15:0] pc, input logic pcs,
                                        input logic lu);
    logic [15:0] r;
    int          s;
    if (pcs) return pc;
    r = a;
    case (op)
      4'h0: return clamp16(int'($signed(a)) + int'($signed(b)));
      4'h1: return clamp16(int'($signed(a)) - int'($signed(b)));
      4'h2: return a ^ b;
      4'h3: begin
        s = int'($signed(a[15:8])) + int'($signed(b[15:8]))
          + int'($signed(a[7:0]))  + int'($signed(b[7:0]));
        return s[15:0];
      end
      4'h4: return a << b[3:0];
      4'h5: begin
        for (int k = 0; k < int'(b[3:0]); k++) r = {r[15], r[15:1]};
        return r;
      end
      4'h6: begin
        for (int k = 0; k < int'(b[3:0]); k++) r = {r[0], r[15:1]};
        return r;
      end
      4'h7: begin
        for (int i = 0; i < 4; i++) begin
          s = int'($signed(a[4*i +: 4])) + int'($signed(b[4*i +: 4]));
          if (s > 7)  s = 7;
          if (s < -8) s = -8;
          r[4*i +: 4] = s[3:0];
        end
        return r;
      end
      4'h8, 4'h9: return (a & 16'hFFFE) + imm;
      4'hA, 4'hB: return lu ? ((a & 16'h00FF) | {imm[7:0], 8'h00})
                            : ((a & 16'hFF00) | {8'h00, imm[7:0]});
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] fwd(input logic [1:0] sel, input logic [15:0] r,
                                      input logic [15:0] wb, input logic [15:0] mem);
    if (sel == 2'b01) return wb;
    if (sel == 2'b10) return mem;
    return r;
  endfunction

  // Starts one cycle: inputs change 1ns after a rising edge
  task automatic run(input string tag, input logic [3:0] op,
                     input logic [15:0] rd1, input logic [15:0] rd2, input logic [15:0] imm,
                     input logic alusrc, input logic fe, input logic stl,
                     input logic [1:0] fa, input logic [1:0] fb,
                     input logic [15:0] mem, input logic [15:0] wb,
                     input logic pcs, input logic lu);
    logic [15:0] a, bf, b, e, got_e;
    int          s;
    bus.EX_instr       = {op, 12'h3A5};
    bus.EX_ReadData1   = rd1;
    bus.EX_ReadData2   = rd2;
    bus.EX_Imm         = imm;
    bus.EX_ALUSrc      = alusrc;
    bus.EX_FLAG_Enable = fe;
    bus.stall          = stl;
    bus.fwdA           = fa;
    bus.fwdB           = fb;
    bus.MEM_ALUResult  = mem;
    bus.WB_WriteData   = wb;
    bus.EX_PCSave      = pcs;
    bus.EX_LoadUpper   = lu;
    a  = fwd(fa, rd1, wb, mem);
    bf = fwd(fb, rd2, wb, mem);
    b  = alusrc ? imm : bf;
    e  = model(op, a, b, imm, bus.EX_pc, pcs, lu);
    exp_res_q.push_back(e);
    exp_sd_q.push_back(bf);
    if (fe && !stl && (op == 4'h0 || op == 4'h1)) begin
      s = (op == 4'h0) ? int'($signed(a)) + int'($signed(b))
                       : int'($signed(a)) - int'($signed(b));
      flags_exp = {e == 16'h0000, (s > 32767) || (s < -32768), e[15]};
    end else if (fe && !stl && (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6)) begin
      flags_exp[2] = (e == 16'h0000);
    end
    #2;
    got_e = exp_res_q.pop_front();
    checks++;
    assert (bus.EX_ALUResult === got_e)
      else begin
        errors++;
        $error("FAIL %s result: got %h expected %h", tag, bus.EX_ALUResult, got_e);
      end
    got_e = exp_sd_q.pop_front();
    checks++;
    assert (bus.EX_StoreData === got_e)
      else begin
        errors++;
        $error("FAIL %s storedata: got %h expected %h", tag, bus.EX_StoreData, got_e);
      end
    @(posedge clk);
    #1;
    checks++;
    assert (bus.FLAGS === flags_exp)
      else begin
        errors++;
        $error("FAIL %s flags: got %b expected %b", tag, bus.FLAGS, flags_exp);
      end
  endtask

  initial begin
    rst                = 1'b1;
    flags_exp          = 3'b000;
    bus.EX_pc          = 16'h0042;
    bus.EX_instr       = 16'h0000;
    bus.EX_ReadData1   = 16'h7000;
    bus.EX_ReadData2   = 16'h2000;
    bus.EX_Imm         = 16'h0000;
    bus.EX_ALUSrc      = 1'b0;
    bus.EX_FLAG_Enable = 1'b1;
    bus.EX_LoadUpper   = 1'b0;
    bus.EX_PCSave      = 1'b0;
    bus.stall          = 1'b0;
    bus.fwdA           = 2'b00;
    bus.fwdB           = 2'b00;
    bus.MEM_ALUResult  = 16'h0000;
    bus.WB_WriteData   = 16'h0000;

    // Flag-setting ADD presented while reset is held must not load
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert (bus.FLAGS === 3'b000)
      else begin
        errors++;
        $error("FAIL reset_hold flags: got %b expected %b", bus.FLAGS, 3'b000);
      end
    rst = 1'b0;

    //   tag        op    rd1       rd2       imm       src  fe   stl  fA     fB     mem       wb        pcs  lu
    run("add_sat",  4'h0, 16'h7000, 16'h2000, 16'h0000, 0,   1,   0,   2'b00, 2'b00, 16'h0000, 16'h0000, 0,   0);
    run("sub_zero", 4'h1, 16'h0005, 16'h0005, 16'h0000, 0,   1,   0,   2'b00, 2'b00, 16'h0000, 16'h0000, 0,   0);
    run("xor_zero", 4'h2, 16'h00FF, 16'h00FF, 16'h0000, 0,   1,   0,   2'b00, 2'b00, 16'h0000, 16'h0000, 0,   0);
    run("lw_fwd",   4'h8, 16'hFFFF, 16'h0000, 16'h0004, 1,   0,   0,   2'b10, 2'b00, 16'h1234, 16'h0000, 0,   0);
    run("add_nsat", 4'h0, 16'h8000, 16'h8000, 16'h0000, 0,   1,   0,   2'b00, 2'b00, 16'h0000, 16'h0000, 0,   0);
    run("add_stal", 4'h0, 16'h0001, 16'h0001, 16'h0000, 0,   1,   1,   2'b00, 2'b00, 16'h0000, 16'h0000, 0,   0);

    // Asynchronous reset pulse between clock edges
    #3;
    rst = 1'b1;
    #1;
    checks++;
    assert (bus.FLAGS === 3'b000)
      else begin
        errors++;
        $error("FAIL rst_pulse flags: got %b expected %b", bus.FLAGS, 3'b000);
      end
    rst       = 1'b0;
    flags_exp = 3'b000;
    @(posedge clk);
    #1;

    run("paddsb",   4'h7, 16'h7878, 16'h1111, 16'h0000, 0,   1,   0,   2'b00, 2'b00, 16'h0000, 16'h0000, 0,   0);
    run("sra4",     4'h5, 16'h8000, 16'h0000, 16'h0004, 1,   1,   0,   2'b00, 2'b00, 16'h0000, 16'h0000, 0,   0);
    run("ror1_wb",  4'h6, 16'h0001, 16'hFFF0, 16'h0000, 0,   1,   0,   2'b00, 2'b01, 16'h0000, 16'h0001, 0,   0);
    run("sll0",     4'h4, 16'h1234, 16'h0010, 16'h0000, 0,   1,   0,   2'b00, 2'b00, 16'h0000, 16'h0000, 0,   0);
    run("sub_nsat", 4'h1, 16'h8000, 16'h0001, 16'h0000, 0,   1,   0,   2'b00, 2'b00, 16'h0000, 16'h0000, 0,   0);
    run("xor_f11",  4'h2, 16'hAAAA, 16'hAAAA, 16'h0000, 0,   1,   0,   2'b11, 2'b11, 16'h5555, 16'h1111, 0,   0);
    run("red_neg",  4'h3, 16'h80FF, 16'h8001, 16'h0000, 0,   1,   0,   2'b00, 2'b00, 16'h0000, 16'h0000, 0,   0);
    run("llb",      4'hA, 16'hABCD, 16'h0000, 16'h0012, 1,   0,   0,   2'b00, 2'b00, 16'h0000, 16'h0000, 0,   0);
    run("lhb",      4'hB, 16'hABCD, 16'h0000, 16'h0034, 1,   0,   0,   2'b00, 2'b00, 16'h0000, 16'h0000, 0,   1);
    run("sw_wrap",  4'h9, 16'h1001, 16'h5A5A, 16'hFFFE, 1,   0,   0,   2'b00, 2'b00, 16'h0000, 16'h0000, 0,   0);
    run("pcsave",   4'hD, 16'h1111, 16'h2222, 16'h0000, 0,   0,   0,   2'b00, 2'b00, 16'h0000, 16'h0000, 1,   0);
    run("hlt_zero", 4'hF, 16'h1111, 16'h2222, 16'h0000, 0,   1,   0,   2'b00, 2'b00, 16'h0000, 16'h0000, 0,   0);
    run("bubble",   4'h0, 16'h0003, 16'h0004, 16'h0000, 0,   0,   0,   2'b00, 2'b00, 16'h0000, 16'h0000, 0,   0);
    run("add_zero", 4'h0, 16'h0003, 16'hFFFD, 16'h0000, 0,   1,   0,   2'b00, 2'b00, 16'h0000, 16'h0000, 0,   0);

    // Literal spot checks of key results independent of the model
    bus.EX_instr = 16'h0000; bus.EX_ReadData1 = 16'h7000; bus.EX_ReadData2 = 16'h2000;
    bus.fwdA = 2'b00; bus.fwdB = 2'b00; bus.EX_ALUSrc = 1'b0; bus.EX_FLAG_Enable = 1'b0;
    #1;
    checks++;
    assert (bus.EX_ALUResult === 16'h7FFF)
      else begin
        errors++;
        $error("FAIL lit_add result: got %h expected %h", bus.EX_ALUResult, 16'h7FFF);
      end
    bus.EX_instr = 16'h8000; bus.EX_ReadData1 = 16'hFFFF; bus.fwdA = 2'b10;
    bus.MEM_ALUResult = 16'h1234; bus.EX_Imm = 16'h0004;
    #1;
    checks++;
    assert (bus.EX_ALUResult === 16'h1238)
      else begin
        errors++;
        $error("FAIL lit_lw result: got %h expected %h", bus.EX_ALUResult, 16'h1238);
      end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter-free ports, all widths fixed; one clock, asynchronous active-high reset.
REQ-002 SHALL have: clk  input  1  rising-edge clock.
REQ-003 SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have: stall  input  1  freezes flag register (same stall that holds the ID/EX register).
REQ-005 SHALL have: EX_instr  input  16  instruction; [15:12] opcode.
REQ-006 SHALL have: EX_pc / EX_ReadData1 / EX_ReadData2 / EX_Imm  input  16 each  PC+2, rs data, rt data, decoded immediate (already sign-extended; memory offsets already <<1).
REQ-007 SHALL have: EX_ALUSrc, EX_FLAG_Enable, EX_LoadUpper, EX_PCSave  input  1 each  control from the ID/EX register.
REQ-008 SHALL have: fwdA, fwdB  input  2 each  forwarding selects: 00 register, 01 WB_WriteData, 10 MEM_ALUResult, 11 register.
REQ-009 SHALL have: MEM_ALUResult, WB_WriteData  input  16 each  forwarded values.
REQ-010 SHALL have: EX_ALUResult  output  16  combinational result to EX/MEM.
REQ-011 SHALL have: EX_StoreData  output  16  forwarded B operand (pre-ALUSrc mux), for SW.
REQ-012 SHALL have: FLAGS  output  3  registered {Z,V,N} for branch resolution.

Function
REQ-013 SHALL form A = fwdA-selected value; Bf = fwdB-selected value; B = EX_ALUSrc ? EX_Imm : Bf.
REQ-014 SHALL compute by opcode: 0000 ADD, 0001 SUB (A-B), both 16-bit signed saturating (+ovf -> 0x7FFF, -ovf -> 0x8000).
REQ-015 SHALL compute 0010 XOR A^B; 0100 SLL, 0101 SRA, 0110 ROR of A by B[3:0] (amount 0 -> A unchanged).
REQ-016 SHALL compute 0011 RED: sign-extend to 16 of (A[15:8]+B[15:8])+(A[7:0]+B[7:0]), bytes signed, 10-bit intermediate, no saturation.
REQ-017 SHALL compute 0111 PADDSB: four independent signed 4-bit nibble adds, each saturating to 0x7/0x8.
REQ-018 SHALL compute 1000 LW / 1001 SW: (A & 0xFFFE) + EX_Imm, wraps mod 2^16, no saturation.
REQ-019 SHALL compute 1010 LLB: (A & 0xFF00) | EX_Imm[7:0]; 1011 LHB (EX_LoadUpper=1): (A & 0x00FF) | (EX_Imm[7:0]<<8).
REQ-020 SHALL output EX_pc when EX_PCSave=1, overriding opcode decode; 1100/1101/1111 otherwise output 0x0000.
REQ-021 SHALL update FLAGS at rising edge only when EX_FLAG_Enable=1 and stall=0; latency one cycle (visible to the instruction two behind).
REQ-022 SHALL update per opcode: ADD/SUB write Z,V,N; XOR/SLL/SRA/ROR write Z only, V,N hold; all other opcodes hold all flags even if FLAG_Enable=1.
REQ-023 SHALL define Z = (result==0), N = result[15], V = saturation occurred, all on the saturated result.
REQ-024 SHALL treat a flushed bubble (all-zero controls) as a no-op: FLAGS hold despite opcode 0000.
REQ-025 SHALL let stall dominate FLAG_Enable when both are asserted: flags hold.

Reset
REQ-026 SHALL clear FLAGS to 3'b000 immediately on rst=1, independent of clk.
REQ-027 SHALL hold FLAGS at 000 while rst=1; the first update is at the first edge after deassertion.
REQ-028 SHALL keep combinational outputs reset-free; during reset they follow inputs.

Structure
REQ-029 SHALL place opcode constants, forwarding-select encodings and flag bit indices in the shared CPU package.
REQ-030 SHALL implement the combinational datapath as one sub-module alu16; the flag register and operand muxes SHALL stay in ex_stage.
REQ-031 SHALL build the flag register from the existing pldff (width 3, wen = FLAG_Enable & ~stall & opcode-qualified).

Verification
REQ-032 SHALL cover: ADD 0x7000+0x2000, FLAG_Enable=1 -> result 0x7FFF, FLAGS Z=0,V=1,N=0 next cycle.
REQ-033 SHALL cover: SUB 0x0005-0x0005 then XOR 0x00FF^0x00FF -> both 0x0000; after XOR Z=1 with V,N held from SUB (0,0).
REQ-034 SHALL cover: fwdA=10 with MEM_ALUResult=0x1234, LW with Imm=0x0004, A register 0xFFFF -> address 0x1238.
REQ-035 SHALL cover: PADDSB 0x7878+0x1111 -> 0x7979; SRA 0x8000 by 4 -> 0xF800; ROR 0x0001 by 1 -> 0x8000.
REQ-036 SHALL cover: flag-setting ADD with stall=1 -> FLAGS unchanged; rst pulse between edges -> FLAGS 000 immediately.
